add_sub_pipe: RTL
=================

Name: add_sub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; successor to the team's 32-bit combinational add/sub unit.
- Splits the WIDTH-bit carry chain into STAGES equal chunks, one chunk per pipeline stage, with a registered carry between stages.
- Adds valid/ready flow control and a status flag set (carry, signed overflow, zero, negative).
- Sits between operand select and writeback in the multi-cycle datapath; also usable standalone as a throughput-1 arithmetic unit.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages (chunks); 1 <= STAGES <= WIDTH; chunk width CW = WIDTH/STAGES.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand set on A/B/sub is valid
in_ready  output  1  block accepts operands this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
sub  input  1  0: S=A+B; 1: S=A-B (A + ~B + 1)
out_valid  output  1  result fields valid
out_ready  input  1  consumer accepts result this cycle
S  output  WIDTH  result, modulo 2^WIDTH
Co  output  1  carry out of MSB (for sub: 1 = no borrow, A>=B unsigned)
V  output  1  signed overflow = carry into MSB XOR carry out of MSB
Z  output  1  S == 0
N  output  1  S[WIDTH-1]

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: all stage valid bits cleared; out_valid=0; S, Co, V, Z and N are 0. Operand and carry registers may also clear to 0.
- Reset mid-operation: every in-flight operation is discarded. On the first cycle after rst deasserts, out_valid=0 and the pipe is empty.
- Advance enable: adv = ~out_valid | out_ready. in_ready = adv (combinational). All stages shift together only when adv=1.
- Accept: an operation is accepted on a rising edge where in_valid & in_ready. If in_valid=0 while adv=1, a bubble (valid=0) enters stage 0.
- Stage k (0..STAGES-1):
  - Computes chunk k as A[k] + (B[k]^{CW{sub}}) + cin, where cin = sub for k=0, otherwise the registered carry from stage k-1.
  - Higher chunks of A, B^sub and the sub bit travel alongside, delayed one register per stage.
  - Finished low result chunks travel alongside, delayed the same way.
- Latency: exactly STAGES cycles from the accept edge to out_valid=1, with no stalls. Throughput: one operation per cycle.
- Stall (out_valid=1, out_ready=0):
  - Entire pipe frozen; outputs hold stable; in_ready=0.
  - Internal bubbles are not compressed.
- Simultaneous out_valid & out_ready & in_valid: the result retires and new operands enter in the same cycle; no loss or duplication.
- Flags are computed in the final stage and registered with S.
  - V uses the carry into the top bit of the last chunk.
  - Z is a full-width compare on the final S.
- STAGES=1 degenerates to a single registered WIDTH-bit add/sub with latency 1.
- Outputs while out_valid=0 hold their last values; consumers must ignore them.
- Ordering: results leave in acceptance order.

Test Plan:
- WIDTH=32, STAGES=4, A=0xFFFFFFFF, B=0x00000001, sub=0 -> after 4 cycles: S=0x00000000, Co=1, V=0, Z=1, N=0. Checks carry rippling across all stage boundaries.
- A=0x7FFFFFFF, B=1, sub=0 -> S=0x80000000, Co=0, V=1, N=1, Z=0. Then A=0x80000000, B=1, sub=1 -> S=0x7FFFFFFF, Co=1, V=1, N=0.
- Subtraction borrow: A=5, B=7, sub=1 -> S=0xFFFFFFFE, Co=0, V=0, N=1. Then A=7, B=5, sub=1 -> S=2, Co=1, V=0, N=0.
- Throughput: 16 random back-to-back ops with in_valid=1 and out_ready=1 -> out_valid is first high at cycle 4 and stays high 16 cycles; every result matches a reference model in order.
- Backpressure: out_ready=0 for 5 cycles while the pipe is full -> in_ready=0, and S and flags are stable through the stall. After out_ready returns, the remaining results retire in order with no loss or duplicate.
- Reset mid-operation: 3 ops in flight, rst=1 for 1 cycle -> next cycle out_valid=0 and S/Co/V/Z/N=0. None of the 3 ops ever appears. A new op issued after reset returns after exactly 4 cycles.
- Parameter sweep: repeat the first scenario with WIDTH=8, STAGES=1 and with WIDTH=16, STAGES=16 -> results and latency (1 and 16 cycles respectively) correct.

Source files
------------

// File: rtl/add_sub_pipe.sv
// Pipelined two's-complement adder/subtractor: the carry chain is split into
// STAGES chunks of WIDTH/STAGES bits with a registered carry between chunks.
module add_sub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             V,
    output logic             Z,
    output logic             N
);
    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        // Operands are carried shrinking: only chunks not yet added travel on.
        localparam int RW = WIDTH - k * CW;

        logic [RW-1:0]         a_in;
        logic [RW-1:0]         b_in;
        logic                  cin;
        logic                  vin;
        logic [CW:0]           sum;
        logic [(k+1)*CW-1:0]   s_nx;
        logic [(k+1)*CW-1:0]   s_r;
        logic                  c_r;
        logic                  v_r;

        if (k == 0) begin : src
            always_comb begin
                a_in = A;
                b_in = B ^ {WIDTH{sub}};
                cin  = sub;
                vin  = in_valid;
            end
            assign s_nx = sum[CW-1:0];
        end else begin : src
            always_comb begin
                a_in = stg[k-1].fwd.a_r;
                b_in = stg[k-1].fwd.b_r;
                cin  = stg[k-1].c_r;
                vin  = stg[k-1].v_r;
            end
            assign s_nx = {sum[CW-1:0], stg[k-1].s_r};
        end

        assign sum = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, cin};

        if (k < LAST) begin : fwd
            logic [RW-CW-1:0] a_r;
            logic [RW-CW-1:0] b_r;
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (adv && vin) begin
                    a_r <= a_in[RW-1:CW];
                    b_r <= b_in[RW-1:CW];
                end
            end
        end

        // Data registers load only for real operations so outputs hold through bubbles.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else if (adv) begin
                v_r <= vin;
                if (vin) begin
                    c_r <= sum[CW];
                    s_r <= s_nx;
                end
            end
        end
    end

    // Carry into the MSB recovered from the MSB sum bit: c = a ^ b ^ s.
    logic msb_cin;
    assign msb_cin = stg[LAST].a_in[CW-1] ^ stg[LAST].b_in[CW-1] ^ stg[LAST].sum[CW-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            V <= 1'b0;
            Z <= 1'b0;
            N <= 1'b0;
        end else if (adv && stg[LAST].vin) begin
            V <= stg[LAST].sum[CW] ^ msb_cin;
            Z <= (stg[LAST].s_nx == '0);
            N <= stg[LAST].s_nx[WIDTH-1];
        end
    end

    assign S         = stg[LAST].s_r;
    assign Co        = stg[LAST].c_r;
    assign out_valid = stg[LAST].v_r;
endmodule
